// File: rtl/wb_initiator.sv
// wb_initiator: single-outstanding Wishbone-style bus initiator with a valid/ready command port.
// Define WB_INITIATOR_TIMEOUT_EN to enable the no-ack timeout abort path.
module wb_initiator #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [3:0]  cmd_sel_i,
  input  logic [29:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic [29:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
  state_e      state_q;
  logic        stb_q, we_q, rsp_valid_q;
  logic [3:0]  sel_q;
  logic [29:0] adr_q;
  logic [31:0] dat_q, rsp_dat_q;
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("wb_initiator: TIMEOUT must be within 2..255");
  end
`ifdef WB_INITIATOR_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q;
  logic       err_q;
  assign rsp_err_o = err_q;
`else
  assign rsp_err_o = 1'b0;
`endif
  assign cmd_ready_o = state_q == IDLE;
  assign stb_o       = stb_q;
  assign we_o        = we_q;
  assign sel_o       = sel_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
`ifdef WB_INITIATOR_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (cmd_valid_i) begin
          stb_q   <= 1'b1;
          we_q    <= cmd_we_i;
          sel_q   <= cmd_sel_i;
          adr_q   <= cmd_adr_i;
          dat_q   <= cmd_we_i ? cmd_dat_i : '0;
          state_q <= BUS;
`ifdef WB_INITIATOR_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        BUS: if (ack_i) begin
          stb_q       <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
          if (!we_q) rsp_dat_q <= dat_i;
`ifdef WB_INITIATOR_TIMEOUT_EN
          err_q       <= 1'b0;
        end else if (cnt_q == TO_LAST) begin
          // ack has priority, so the abort only fires on an un-acked final cycle
          stb_q       <= 1'b0;
          err_q       <= 1'b1;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end else begin
          cnt_q <= cnt_q + 8'd1;
`endif
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
- Single-outstanding Wishbone-style bus initiator; the requesting end of the stb/we/sel/adr/dat/ack word-addressed slave interface used by the on-chip RAM.
- Accepts one command at a time on a valid/ready command port, runs one bus cycle, and returns read data or completion on a one-cycle response strobe.
- Sits between CPU/DMA-style logic and RAM or peripheral slaves; also serves as a bench driver for slaves.

Parameters:
- TIMEOUT, 16, cycles stb_o may stay high without ack_i before the cycle aborts with error (valid range 2..255).

Ports:
- clk_i  in  1  system clock; all state changes on the rising edge
- rst_i  in  1  asynchronous, active-low reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  initiator can accept a command
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_sel_i  in  4  byte lane enables
- cmd_adr_i  in  30  word address
- cmd_dat_i  in  32  write data
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_dat_o  out  32  read data (captured on ack)
- rsp_err_o  out  1  valid with rsp_valid_o; 1 = timeout abort
- stb_o  out  1  bus strobe
- we_o  out  1  bus write enable
- sel_o  out  4  bus byte selects
- adr_o  out  30  bus word address
- dat_o  out  32  bus write data
- dat_i  in  32  bus read data
- ack_i  in  1  slave acknowledge

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE; stb_o=0, we_o=0, sel_o=0, adr_o=0, dat_o=0, rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0; timeout counter 0. cmd_ready_o=1 once out of reset (combinational from IDLE).
- States: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready_o=1.
  - On an edge with cmd_valid_i=1, register we/sel/adr/dat onto the bus outputs, set stb_o=1, clear the counter and go to BUS.
  - For reads, dat_o is driven with 0.
- BUS:
  - cmd_ready_o=0; bus outputs held stable.
  - ack_i is sampled on each edge. On an edge with ack_i=1: stb_o=0; rsp_dat_o=dat_i for reads (unchanged for writes); rsp_err_o=0; rsp_valid_o=1; go to RESP.
  - A slave acking combinationally in the first stb cycle completes in that cycle: bus phase minimum 1 cycle.
  - Otherwise the counter increments. At counter==TIMEOUT-1 without ack: stb_o=0, rsp_err_o=1, rsp_valid_o=1, rsp_dat_o unchanged, go to RESP.
  - If ack_i and timeout coincide on the same edge, ack wins (err=0).
- RESP:
  - rsp_valid_o high exactly one cycle; next edge clears rsp_valid_o and returns to IDLE.
  - rsp_dat_o and rsp_err_o hold until the next response.
  - cmd_ready_o=0 in RESP, so back-to-back throughput is 1 command per 3 cycles with a zero-wait slave.
- ack_i outside BUS is ignored; no response is generated.
- cmd_* inputs are ignored when cmd_ready_o=0. No command queueing.
- Reset mid-BUS: stb_o drops immediately (asynchronous); the in-flight command is lost and no response is issued.
- The counter width is 8 bits and it never wraps, because TIMEOUT<=255.

Optional Feature:
- Macro: WB_INITIATOR_TIMEOUT_EN
- Defined: timeout counter and abort path present as described above.
- Undefined: no counter; BUS waits for ack_i indefinitely; rsp_err_o is tied to 0.

Test Plan:
- Write, zero-wait slave: cmd we=1, sel=4'hF, adr=30'h10, dat=32'hDEADBEEF. Required response:
  - stb_o=1 for 1 cycle with those values on the bus.
  - rsp_valid_o pulses once with err=0.
  - cmd_ready_o low 2 cycles.
- Read-back: cmd we=0, adr=30'h10, slave returns 32'hDEADBEEF with ack. Required response: rsp_dat_o=32'hDEADBEEF, rsp_err_o=0, dat_o=0 during the cycle.
- Byte-lane write: sel=4'b0010, dat=32'h0000AB00, adr=30'h10, then read adr=30'h10. Required response: rsp_dat_o=32'hDEADABEF.
- Wait states: slave delays ack by 5 cycles. Required response:
  - stb_o high 6 cycles with adr/we/sel/dat stable.
  - Single rsp_valid_o pulse.
- Timeout (macro defined, TIMEOUT=16): slave never acks. Required response:
  - stb_o high exactly 16 cycles.
  - rsp_valid_o=1 with rsp_err_o=1.
  - Next command is accepted normally.
  - With the macro undefined: stb_o stays high for 100+ cycles and no response is issued.
- Reset mid-cycle: assert rst_i low 2 cycles into a 5-wait-state read. Required response:
  - stb_o=0 immediately.
  - No rsp_valid_o pulse.
  - cmd_ready_o=1 after release.
  - A stray ack_i=1 in IDLE produces no response.
